// File: rtl/riscv_pkg.sv
// Shared datapath widths, ALU operation encodings and the EX-stage record used by
// the ID/EX operand stage.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int OP_W       = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [OP_W-1:0] BUBBLE_ALUOP = 4'b0000;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       immediate;
        logic [OP_W-1:0]       alu_op;
        logic                  alu_src;
        logic                  mem_read;
        logic                  reg_write;
    } ex_stage_t;

    // A bubble is an all-zero record; the ALU op is pinned to the bubble encoding.
    function automatic ex_stage_t bubble_stage();
        ex_stage_t s;
        s        = '0;
        s.alu_op = BUBBLE_ALUOP;
        return s;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-side handshake and decoded-instruction bundle feeding the ID/EX register.
interface id_ex_operand_stage_if;
    import riscv_pkg::*;

    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_immediate;
    logic [OP_W-1:0]       id_ALUOp;
    logic                  id_ALUSrc;
    logic                  id_mem_read;
    logic                  id_reg_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_immediate, id_ALUOp, id_ALUSrc, id_mem_read, id_reg_write,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_immediate, id_ALUOp, id_ALUSrc, id_mem_read, id_reg_write,
        output id_ready
    );

endinterface

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Three-way priority operand select (high source > low source > base data);
// register index 0 never takes a forwarded value.
module operand_forward_mux
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  hi_en,
    input  logic [REG_ADDR_W-1:0] hi_rd,
    input  logic [XLEN-1:0]       hi_data,
    input  logic                  lo_en,
    input  logic [REG_ADDR_W-1:0] lo_rd,
    input  logic [XLEN-1:0]       lo_data,
    input  logic [XLEN-1:0]       base_data,
    output logic [XLEN-1:0]       sel_data
);

    // Priority select; hi_rd/lo_rd equal to rs implies they are also non-zero here.
    always_comb begin
        sel_data = base_data;
        if (rs == {REG_ADDR_W{1'b0}}) begin
            sel_data = base_data;
        end else if (hi_en && (hi_rd == rs)) begin
            sel_data = hi_data;
        end else if (lo_en && (lo_rd == rs)) begin
            sel_data = lo_data;
        end else begin
            sel_data = base_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall, flush, capture-time MEM/WB bypass and
// EX-time forwarding. Defining ID_EX_PERF_CNT_EN adds stall_count/flush_count outputs.
module id_ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    id_ex_operand_stage_if.slave  id,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       operand_A,
    output logic [XLEN-1:0]       operand_B,
    output logic [XLEN-1:0]       immediate,
    output logic [OP_W-1:0]       ALUOp,
    output logic                  ALUSrc,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    ex_stage_t       ex_r;
    ex_stage_t       ex_next_s;
    logic            stall_s;
    logic [XLEN-1:0] cap_rs1_data_s;
    logic [XLEN-1:0] cap_rs2_data_s;
    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;

    // Load-use hazard: rs2 is checked even for immediate forms since stores read it.
    always_comb begin
        stall_s = ex_r.valid & ex_r.mem_read & (ex_r.rd != {REG_ADDR_W{1'b0}}) &
                  id.id_valid & ((ex_r.rd == id.id_rs1) | (ex_r.rd == id.id_rs2));
    end

    assign id.id_ready = ~stall_s;

    // Capture-time bypass covers the register file's read-before-write window.
    operand_forward_mux u_cap_rs1 (
        .rs(id.id_rs1), .hi_en(1'b0), .hi_rd({REG_ADDR_W{1'b0}}), .hi_data({XLEN{1'b0}}),
        .lo_en(memwb_reg_write), .lo_rd(memwb_rd), .lo_data(memwb_result),
        .base_data(id.id_rs1_data), .sel_data(cap_rs1_data_s)
    );

    operand_forward_mux u_cap_rs2 (
        .rs(id.id_rs2), .hi_en(1'b0), .hi_rd({REG_ADDR_W{1'b0}}), .hi_data({XLEN{1'b0}}),
        .lo_en(memwb_reg_write), .lo_rd(memwb_rd), .lo_data(memwb_result),
        .base_data(id.id_rs2_data), .sel_data(cap_rs2_data_s)
    );

    // Next EX contents: flush > stall > valid capture > idle bubble.
    always_comb begin
        ex_next_s = bubble_stage();
        if (flush) begin
            ex_next_s = bubble_stage();
        end else if (stall_s) begin
            ex_next_s = bubble_stage();
        end else if (id.id_valid) begin
            ex_next_s.valid     = 1'b1;
            ex_next_s.rs1       = id.id_rs1;
            ex_next_s.rs2       = id.id_rs2;
            ex_next_s.rd        = id.id_rd;
            ex_next_s.rs1_data  = cap_rs1_data_s;
            ex_next_s.rs2_data  = cap_rs2_data_s;
            ex_next_s.immediate = id.id_immediate;
            ex_next_s.alu_op    = id.id_ALUOp;
            ex_next_s.alu_src   = id.id_ALUSrc;
            ex_next_s.mem_read  = id.id_mem_read;
            ex_next_s.reg_write = id.id_reg_write;
        end else begin
            ex_next_s = bubble_stage();
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r <= bubble_stage();
        end else begin
            ex_r <= ex_next_s;
        end
    end

    // EX-time forwarding, EX/MEM ahead of MEM/WB, applied to A and B independently.
    operand_forward_mux u_fwd_a (
        .rs(ex_r.rs1), .hi_en(exmem_reg_write), .hi_rd(exmem_rd), .hi_data(exmem_result),
        .lo_en(memwb_reg_write), .lo_rd(memwb_rd), .lo_data(memwb_result),
        .base_data(ex_r.rs1_data), .sel_data(fwd_a_s)
    );

    operand_forward_mux u_fwd_b (
        .rs(ex_r.rs2), .hi_en(exmem_reg_write), .hi_rd(exmem_rd), .hi_data(exmem_result),
        .lo_en(memwb_reg_write), .lo_rd(memwb_rd), .lo_data(memwb_result),
        .base_data(ex_r.rs2_data), .sel_data(fwd_b_s)
    );

    // ALU-facing outputs; a bubble presents zero operands.
    always_comb begin
        if (ex_r.valid) begin
            operand_A = fwd_a_s;
            operand_B = fwd_b_s;
        end else begin
            operand_A = {XLEN{1'b0}};
            operand_B = {XLEN{1'b0}};
        end
        ex_valid     = ex_r.valid;
        immediate    = ex_r.immediate;
        ALUOp        = ex_r.alu_op;
        ALUSrc       = ex_r.alu_src;
        ex_rd        = ex_r.rd;
        ex_reg_write = ex_r.reg_write;
        ex_mem_read  = ex_r.mem_read;
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_count_r;
    logic [31:0] flush_count_r;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 32'd0;
            flush_count_r <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_count_r <= stall_count_r + 32'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush) begin
                flush_count_r <= flush_count_r + 32'd1;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed table-driven bench for id_ex_operand_stage, with hand sequences for reset,
// capture-time bypass and mid-stream reset; counters are checked when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_operand_stage;
    import riscv_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [XLEN-1:0]       exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [XLEN-1:0]       memwb_result;
    logic                  ex_valid;
    logic [XLEN-1:0]       operand_A;
    logic [XLEN-1:0]       operand_B;
    logic [XLEN-1:0]       immediate;
    logic [OP_W-1:0]       ALUOp;
    logic                  ALUSrc;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]           stall_count;
    logic [31:0]           flush_count;
`endif

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id(bus), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .operand_A(operand_A), .operand_B(operand_B),
        .immediate(immediate), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  op;
        logic        src, mr, rw, fl;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        e_rdy, e_v;
        logic [31:0] e_a, e_b;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[13];

    function automatic vec_t mk(
        logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
        logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
        logic [3:0] op, logic src, logic mr, logic rw, logic fl,
        logic xw, logic [4:0] xrd, logic [31:0] xres,
        logic ww, logic [4:0] wrd, logic [31:0] wres,
        logic e_rdy, logic e_v, logic [31:0] e_a, logic [31:0] e_b);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.d1 = d1; t.d2 = d2; t.imm = imm; t.op = op;
        t.src = src; t.mr = mr; t.rw = rw; t.fl = fl;
        t.xw = xw; t.xrd = xrd; t.xres = xres;
        t.ww = ww; t.wrd = wrd; t.wres = wres;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_a = e_a; t.e_b = e_b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid = t.v; bus.id_rs1 = t.rs1; bus.id_rs2 = t.rs2; bus.id_rd = t.rd;
        bus.id_rs1_data = t.d1; bus.id_rs2_data = t.d2; bus.id_immediate = t.imm;
        bus.id_ALUOp = t.op; bus.id_ALUSrc = t.src;
        bus.id_mem_read = t.mr; bus.id_reg_write = t.rw;
        flush = t.fl;
        exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
        memwb_reg_write = t.ww; memwb_rd = t.wrd; memwb_result = t.wres;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, ".operand_A"}, operand_A, 32'd0);
        chk({tag, ".operand_B"}, operand_B, 32'd0);
        chk({tag, ".ALUOp"}, {28'd0, ALUOp}, 32'd0);
        chk({tag, ".ex_rd"}, {27'd0, ex_rd}, 32'd0);
        chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
        chk({tag, ".ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    endtask

    initial begin
        vec_t t;
        //          v rs1 rs2 rd   d1        d2        imm      op  src mr rw fl  xw xrd xres       ww wrd wres      rdy v  A         B
        vecs[0]  = mk(1, 5'd1, 5'd3, 5'd4, 32'h1, 32'h3, 32'h0, 4'd1, 0, 0, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 32'h1, 32'h3);
        vecs[1]  = mk(1, 5'd5, 5'd6, 5'd8, 32'h55, 32'h66, 32'h100, 4'd2, 1, 0, 1, 0, 1, 5'd5, 32'h10, 1, 5'd5, 32'h20, 1, 1, 32'h10, 32'h66);
        vecs[2]  = mk(1, 5'd5, 5'd6, 5'd8, 32'h55, 32'h66, 32'h100, 4'd2, 1, 0, 1, 0, 1, 5'd0, 32'h10, 0, 5'd0, 32'h0, 1, 1, 32'h55, 32'h66);
        vecs[3]  = mk(1, 5'd9, 5'd10, 5'd11, 32'h9, 32'hA, 32'h0, 4'd3, 0, 0, 1, 0, 1, 5'd10, 32'hAA, 1, 5'd10, 32'h77, 1, 1, 32'h9, 32'hAA);
        vecs[4]  = mk(1, 5'd2, 5'd0, 5'd7, 32'h200, 32'h0, 32'h4, 4'd0, 1, 1, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 32'h200, 32'h0);
        vecs[5]  = mk(1, 5'd1, 5'd7, 5'd12, 32'h1, 32'h0, 32'h5, 4'd1, 1, 0, 1, 0, 1, 5'd7, 32'hDEAD, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0);
        vecs[6]  = mk(1, 5'd1, 5'd7, 5'd12, 32'h1, 32'h0, 32'h5, 4'd1, 1, 0, 1, 0, 1, 5'd7, 32'hDEAD, 0, 5'd0, 32'h0, 1, 1, 32'h1, 32'hDEAD);
        vecs[7]  = mk(1, 5'd3, 5'd4, 5'd13, 32'h3, 32'h4, 32'h0, 4'd1, 0, 0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 32'h0, 32'h0);
        vecs[8]  = mk(1, 5'd1, 5'd2, 5'd14, 32'h11, 32'h22, 32'h8, 4'd0, 1, 1, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 32'h11, 32'h22);
        vecs[9]  = mk(1, 5'd14, 5'd0, 5'd15, 32'h0, 32'h0, 32'h0, 4'd2, 0, 0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0);
        vecs[10] = mk(1, 5'd14, 5'd0, 5'd15, 32'h0, 32'h0, 32'h0, 4'd2, 0, 0, 1, 0, 1, 5'd14, 32'hBEEF, 0, 5'd0, 32'h0, 1, 1, 32'hBEEF, 32'h0);
        vecs[11] = mk(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 32'h0, 32'h0);
        vecs[12] = mk(1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 4'd3, 0, 0, 1, 0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE, 1, 1, 32'h0, 32'h0);

        // Reset held two cycles, then released with nothing in ID.
        reset = 1'b1;
        drive(vecs[11]);
        repeat (2) @(posedge clk);
        #1;
        chk_bubble("reset_held");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_bubble("reset_release");

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.id_ready", i), {31'd0, bus.id_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d.operand_A", i), operand_A, vecs[i].e_a);
            chk($sformatf("v%0d.operand_B", i), operand_B, vecs[i].e_b);
            chk($sformatf("v%0d.ALUOp", i), {28'd0, ALUOp}, vecs[i].e_v ? {28'd0, vecs[i].op} : 32'd0);
            chk($sformatf("v%0d.immediate", i), immediate, vecs[i].e_v ? vecs[i].imm : 32'd0);
            chk($sformatf("v%0d.ALUSrc", i), {31'd0, ALUSrc}, {31'd0, vecs[i].e_v & vecs[i].src});
            chk($sformatf("v%0d.ex_rd", i), {27'd0, ex_rd}, vecs[i].e_v ? {27'd0, vecs[i].rd} : 32'd0);
            chk($sformatf("v%0d.ex_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].e_v & vecs[i].rw});
            chk($sformatf("v%0d.ex_mem_read", i), {31'd0, ex_mem_read}, {31'd0, vecs[i].e_v & vecs[i].mr});
        end

`ifdef ID_EX_PERF_CNT_EN
        // Stalls occurred at v5 and v9; flushes at v7 and v9.
        chk("stall_count", stall_count, 32'd2);
        chk("flush_count", flush_count, 32'd2);
`endif

        // Capture-time MEM/WB bypass: the writer leaves MEM/WB right after the capture edge.
        @(negedge clk);
        t = mk(1, 5'd6, 5'd9, 5'd2, 32'h1, 32'h2, 32'h0, 4'd4, 0, 0, 1, 0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h600, 1, 1, 32'h0, 32'h0);
        drive(t);
        @(posedge clk);
        #1;
        memwb_reg_write = 1'b0;
        memwb_rd = 5'd0;
        memwb_result = 32'h0;
        bus.id_valid = 1'b0;
        #1;
        chk("bypass.operand_A", operand_A, 32'h600);
        chk("bypass.operand_B", operand_B, 32'h2);
        chk("bypass.ex_valid", {31'd0, ex_valid}, 32'd1);

        // Reset asserted with a live instruction in EX and another in ID.
        @(negedge clk);
        t = mk(1, 5'd3, 5'd4, 5'd5, 32'h33, 32'h44, 32'h9, 4'd5, 1, 1, 1, 0, 1, 5'd3, 32'h1234, 1, 5'd4, 32'h5678, 1, 1, 32'h0, 32'h0);
        drive(t);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_bubble("midreset");
        chk("midreset.immediate", immediate, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("midreset.stall_count", stall_count, 32'd0);
        chk("midreset.flush_count", flush_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
